// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one RV32I ALU between two requesters, registered response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module alu_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_invalid_op
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic [0:0]       state_q, state_d;
    logic             id_q, id_d;
    logic [31:0]      out_q, out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;

    logic             can_accept;
    logic             accept;
    logic [N_REQ-1:0] gnt;

    logic [3:0]       op;
    logic [31:0]      a, b;
    logic [32:0]      sum, diff;
    logic [31:0]      alu_out;
    logic             alu_ovf, alu_inv;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    // Readies are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        can_accept = rst_n && ((state_q == S_EMPTY) || rsp_ready);
        gnt = '0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                gnt = 2'b01;
`else
                gnt = last_grant_q ? 2'b01 : 2'b10;
`endif
            end else begin
                gnt = {req1_valid, req0_valid};
            end
        end
        accept = |gnt;
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        op   = gnt[1] ? req1_op  : req0_op;
        a    = gnt[1] ? req1_in1 : req0_in1;
        b    = gnt[1] ? req1_in2 : req0_in2;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        alu_out = '0;
        alu_ovf = 1'b0;
        alu_inv = 1'b0;
        case (op)
            OP_ADD: begin
                alu_out = sum[31:0];
                alu_ovf = sum[32];
            end
            OP_SUB: begin
                alu_out = diff[31:0];
                alu_ovf = diff[32];
            end
            OP_SLL:  alu_out = a << b[4:0];
            OP_SLT:  alu_out = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: alu_out = {31'b0, a < b};
            OP_XOR:  alu_out = a ^ b;
            OP_SRL:  alu_out = a >> b[4:0];
            OP_SRA:  alu_out = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   alu_out = a | b;
            OP_AND:  alu_out = a & b;
            default: alu_inv = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        out_d   = out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        if (accept) begin
            state_d = S_FULL;
            id_d    = gnt[1];
            out_d   = alu_out;
            zero_d  = (alu_out == 32'd0);
            ovf_d   = alu_ovf;
            inv_d   = alu_inv;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_d = gnt[1];
`endif
        end else if ((state_q == S_FULL) && rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            id_q    <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign rsp_valid      = (state_q == S_FULL);
    assign rsp_id         = id_q;
    assign rsp_out        = out_q;
    assign rsp_zero       = zero_q;
    assign rsp_overflow   = ovf_q;
    assign rsp_invalid_op = inv_q;

endmodule
